bit_unstuff: RTL and testbench

- Receive-side bit-unstuffing engine for the USB 1.1 RX path.
- Sits between the NRZI decoder and the RX shift register.
- Tracks runs of consecutive decoded '1's, flags and removes the stuffed bit, detects bit-stuff violations, and counts removed bits per packet.
- Parametrised successor to the fixed six-ones stuff detector: run length is configurable, and error detection, data pass-through and statistics are added.

---
 rtl/bit_unstuff.sv | 89 ++++++++
 tb/tb_bit_unstuff.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_unstuff.sv
// bit_unstuff: receive-side USB bit-unstuffing engine. It tracks runs of
// decoded '1's, drops the stuffed bit that follows RUN_LEN ones, flags
// stuffed '1's as violations, and counts the stuffed bits it removes.
// Latency: d_out/d_out_valid appear one cycle after the shift_en strobe.
//          bit_stuff is decoded directly from the run register.
// Backpressure: none. shift_en may strobe every cycle.
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset
//   clear           synchronous packet restart (highest priority)
//   shift_en/d_orig strobe plus decoded data bit from the NRZI decoder
//   bit_stuff       the next strobed bit is stuffed; RX shifter must skip it
//   d_out/_valid    registered de-stuffed bit and its one-cycle qualifier
//   stuff_err       sticky violation flag (a stuffed bit was '1')
//   stuff_cnt       saturating count of stuffed bits removed since clear
module bit_unstuff #(
  parameter int RUN_LEN = 6,
  parameter int CNT_W   = 8,
  parameter int ERR_EN  = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             d_orig,
  output logic             bit_stuff,
  output logic             d_out,
  output logic             d_out_valid,
  output logic             stuff_err,
  output logic [CNT_W-1:0] stuff_cnt
);

  localparam int RW = $clog2(RUN_LEN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);

  logic [RW-1:0]    r_run_cnt;
  logic             r_d_out;
  logic             r_d_out_valid;
  logic             r_stuff_err;
  logic [CNT_W-1:0] r_stuff_cnt;
  logic             w_bit_stuff;
  logic             w_cnt_sat;

  // A run can never exceed RUN_MAX: the strobe after RUN_MAX ones is always
  // treated as stuffed and restarts the counter, even if it was a '1'.
  assign w_bit_stuff = (r_run_cnt == RUN_MAX);
  assign w_cnt_sat   = &r_stuff_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_run_cnt     <= '0;
      r_d_out       <= 1'b0;
      r_d_out_valid <= 1'b0;
      r_stuff_err   <= 1'b0;
      r_stuff_cnt   <= '0;
    end else if (clear) begin
      // A strobe coinciding with clear is ignored entirely; d_out keeps its
      // last value so downstream sees no spurious data change.
      r_run_cnt     <= '0;
      r_d_out_valid <= 1'b0;
      r_stuff_err   <= 1'b0;
      r_stuff_cnt   <= '0;
    end else begin
      r_d_out_valid <= 1'b0;
      if (shift_en) begin
        if (w_bit_stuff) begin
          // Stuffed bit: discard it and restart the run with no resync.
          r_run_cnt <= '0;
          if (!w_cnt_sat) begin
            r_stuff_cnt <= r_stuff_cnt + 1'b1;
          end
          if ((ERR_EN != 0) && d_orig) begin
            r_stuff_err <= 1'b1;
          end
        end else begin
          r_run_cnt     <= d_orig ? (r_run_cnt + 1'b1) : '0;
          r_d_out       <= d_orig;
          r_d_out_valid <= 1'b1;
        end
      end
    end
  end

  assign bit_stuff   = w_bit_stuff;
  assign d_out       = r_d_out;
  assign d_out_valid = r_d_out_valid;
  assign stuff_err   = r_stuff_err;
  assign stuff_cnt   = r_stuff_cnt;

endmodule

// File: tb/tb_bit_unstuff.sv
// tb_bit_unstuff: testbench for three bit_unstuff configurations that share one
// stimulus stream: (RUN_LEN=6, CNT_W=8, ERR_EN=1), (6, 8, 0) and (3, 2, 1).
// A per-configuration queue model predicts outputs, and a negedge monitor
// scores every DUT output against the model.
module tb_bit_unstuff;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic clear = 1'b0;
  logic shift_en = 1'b0;
  logic d_orig = 1'b0;

  logic       bs[3];
  logic       dout[3];
  logic       dv[3];
  logic       err[3];
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  bit_unstuff #(.RUN_LEN(6), .CNT_W(8), .ERR_EN(1)) u_dut0 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .shift_en(shift_en), .d_orig(d_orig),
    .bit_stuff(bs[0]), .d_out(dout[0]), .d_out_valid(dv[0]),
    .stuff_err(err[0]), .stuff_cnt(cnt0));

  bit_unstuff #(.RUN_LEN(6), .CNT_W(8), .ERR_EN(0)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .shift_en(shift_en), .d_orig(d_orig),
    .bit_stuff(bs[1]), .d_out(dout[1]), .d_out_valid(dv[1]),
    .stuff_err(err[1]), .stuff_cnt(cnt1));

  bit_unstuff #(.RUN_LEN(3), .CNT_W(2), .ERR_EN(1)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .shift_en(shift_en), .d_orig(d_orig),
    .bit_stuff(bs[2]), .d_out(dout[2]), .d_out_valid(dv[2]),
    .stuff_err(err[2]), .stuff_cnt(cnt2));

  // Configuration table for the reference model.
  int RL[3]   = '{6, 6, 3};
  int CMAX[3] = '{255, 255, 3};
  bit EE[3]   = '{1'b1, 1'b0, 1'b1};

  // Model state: bits accepted since the last run boundary (stuff, clear, reset).
  bit hist[3][$];
  bit exp_q[3][$];
  int m_cnt[3];
  bit m_err[3];
  bit last_d[3];

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input int c, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, c, act, exp, $time);
    end
  endtask

  function automatic int trail_ones(input int c);
    int n = 0;
    for (int i = hist[c].size() - 1; i >= 0; i--) begin
      if (!hist[c][i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int cnt_of(input int c);
    if (c == 0) return int'(cnt0);
    if (c == 1) return int'(cnt1);
    return int'(cnt2);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      hist[c].delete();
      exp_q[c].delete();
      m_cnt[c]  = 0;
      m_err[c]  = 1'b0;
      last_d[c] = 1'b0;
    end
  endtask

  // Apply the spec rules for one clock edge, for every configuration.
  task automatic model_edge(input bit clr, input bit en, input bit d);
    for (int c = 0; c < 3; c++) begin
      if (clr) begin
        hist[c].delete();
        m_cnt[c] = 0;
        m_err[c] = 1'b0;
      end else if (en) begin
        if (trail_ones(c) == RL[c]) begin
          hist[c].delete();
          if (m_cnt[c] < CMAX[c]) m_cnt[c]++;
          if (d && EE[c]) m_err[c] = 1'b1;
        end else begin
          hist[c].push_back(d);
          if (hist[c].size() > 32) void'(hist[c].pop_front());
          exp_q[c].push_back(d);
        end
      end
    end
  endtask

  // Drive one cycle of inputs from a negedge; returns at the following negedge.
  task automatic send(input bit d, input bit clr = 1'b0, input bit en = 1'b1);
    d_orig   = d;
    clear    = clr;
    shift_en = en;
    @(posedge clk);
    model_edge(clr, en, d);
    @(negedge clk);
    shift_en = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    for (int c = 0; c < 3; c++) begin
      chk({nm, "_bit_stuff"}, c, int'(bs[c]), 0);
      chk({nm, "_d_out"}, c, int'(dout[c]), 0);
      chk({nm, "_d_out_valid"}, c, int'(dv[c]), 0);
      chk({nm, "_stuff_err"}, c, int'(err[c]), 0);
      chk({nm, "_stuff_cnt"}, c, cnt_of(c), 0);
    end
  endtask

  // Monitor: scores every DUT output each cycle, decoupled from the driver.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < 3; c++) begin
        if (dv[c]) begin
          if (exp_q[c].size() == 0) begin
            chk("unexpected_valid", c, 1, 0);
          end else begin
            last_d[c] = exp_q[c].pop_front();
            chk("d_out", c, int'(dout[c]), int'(last_d[c]));
          end
        end else begin
          if (exp_q[c].size() != 0) begin
            chk("missing_valid", c, 0, 1);
            void'(exp_q[c].pop_front());
          end
          chk("d_out_hold", c, int'(dout[c]), int'(last_d[c]));
        end
        chk("bit_stuff", c, int'(bs[c]), int'(trail_ones(c) == RL[c]));
        chk("stuff_cnt", c, cnt_of(c), m_cnt[c]);
        chk("stuff_err", c, int'(err[c]), int'(m_err[c]));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    n_rst  = 1'b1;
    mon_en = 1'b1;

    // 6 ones then a stuffed 0.
    for (int i = 0; i < 5; i++) send(1'b1);
    chk("bs_before_6th", 0, int'(bs[0]), 0);
    send(1'b1);
    chk("bs_after_6th", 0, int'(bs[0]), 1);
    send(1'b0);
    chk("cnt_after_stuff", 0, int'(cnt0), 1);
    chk("err_after_stuff", 0, int'(err[0]), 0);
    chk("bs_after_stuff", 0, int'(bs[0]), 0);
    send(1'b0, 1'b1, 1'b0);

    // 5 ones, 0, 5 ones: no stuffing for RUN_LEN=6.
    for (int i = 0; i < 5; i++) send(1'b1);
    send(1'b0);
    for (int i = 0; i < 5; i++) send(1'b1);
    chk("no_stuff_cnt", 0, int'(cnt0), 0);
    send(1'b0, 1'b1, 1'b0);

    // 7 ones: the 7th is an erroneous stuffed 1.
    for (int i = 0; i < 6; i++) send(1'b1);
    chk("bs_before_7th", 0, int'(bs[0]), 1);
    send(1'b1);
    chk("err_7_ones", 0, int'(err[0]), 1);
    chk("err_7_ones_noerr_en", 1, int'(err[1]), 0);
    chk("cnt_7_ones_noerr_en", 1, int'(cnt1), 1);
    for (int i = 0; i < 20; i++) send(1'($urandom_range(0, 1)));
    chk("err_sticky", 0, int'(err[0]), 1);
    send(1'b0, 1'b1, 1'b0);
    chk("err_cleared", 0, int'(err[0]), 0);
    chk("cnt_cleared", 0, int'(cnt0), 0);

    // "1110" x5: saturates the 2-bit counter of the RUN_LEN=3 instance.
    for (int r = 0; r < 5; r++) begin
      send(1'b1); send(1'b1); send(1'b1); send(1'b0);
    end
    chk("cnt_saturated", 2, int'(cnt2), 3);
    chk("no_stuff_rl6", 0, int'(cnt0), 0);
    send(1'b0, 1'b1, 1'b0);

    // clear coincident with the 6th one.
    for (int i = 0; i < 5; i++) send(1'b1);
    send(1'b1, 1'b1, 1'b1);
    chk("bs_after_clear", 0, int'(bs[0]), 0);
    for (int i = 0; i < 5; i++) send(1'b1);
    chk("bs_5_after_clear", 0, int'(bs[0]), 0);
    send(1'b1);
    chk("bs_6_after_clear", 0, int'(bs[0]), 1);
    send(1'b0);

    // Asynchronous reset mid-run, checked between clock edges.
    for (int i = 0; i < 4; i++) send(1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b1);
    chk("bs_new_run", 0, int'(bs[0]), 0);

    // Randomised traffic: ones-biased data, gaps, occasional clears.
    for (int i = 0; i < 600; i++) begin
      send(1'($urandom_range(0, 9) < 8),
           1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 3) != 0));
    end

    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
